pixel_frame_streamer: RTL

- Transmit side of the Feature_Extractor pixel interface.
- Holds one IMG_WIDTH x IMG_HEIGHT 8-bit frame in an internal buffer, loaded through a simple write port.
- On launch: pulses start_signal, streams the frame in raster order on pixel_valid_in/pixel_in, then waits for final_done_signal (with timeout) before reporting completion.
- Replaces the bench-driven pixel source in the integrated NPU top.

---
 rtl/npu_stream_pkg.sv | 20 ++
 rtl/frame_buffer_ram.sv | 30 +++
 rtl/pixel_frame_streamer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/npu_stream_pkg.sv
// Shared types and default frame geometry for the Feature_Extractor pixel
// source: state encoding, pixel type and frame size.
package npu_stream_pkg;

    localparam int DEF_IMG_WIDTH  = 32;
    localparam int DEF_IMG_HEIGHT = 32;
    localparam int DEF_PIX_W      = 8;
    localparam int FRAME_PIXELS   = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;

    typedef logic [DEF_PIX_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        STREAM,
        GAP,
        WAIT_DONE
    } stream_state_t;

endpackage

// File: rtl/frame_buffer_ram.sv
// Single-port-write / single-port-read frame store with a registered read
// (one cycle from rd_addr to rd_data).
module frame_buffer_ram
    import npu_stream_pkg::*;
#(
    parameter int DEPTH  = FRAME_PIXELS,
    parameter int WIDTH  = DEF_PIX_W,
    parameter int ADDR_W = $clog2(FRAME_PIXELS)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pixel_frame_streamer.sv
// Transmit side of the Feature_Extractor pixel interface: streams a buffered
// frame in raster order after a start pulse, then waits for completion.
module pixel_frame_streamer
    import npu_stream_pkg::*;
#(
    parameter int IMG_WIDTH      = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT     = DEF_IMG_HEIGHT,
    parameter int PIX_W          = DEF_PIX_W,
    parameter int ROW_GAP        = 0,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int ADDR_W         = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              launch,
    input  logic              final_done_signal,
    output logic              start_signal,
    output logic              pixel_valid_in,
    output logic [PIX_W-1:0]  pixel_in,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              wr_err,
    output logic              timeout_err
);

    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;

    stream_state_t     state, state_nxt;
    logic [15:0]       col, row, gap_cnt;
    logic [31:0]       to_cnt;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_en;
    logic [PIX_W-1:0]  rd_data;
    logic              addr_ok, ram_we;
    logic              last_col, last_row, to_hit, accept_launch, done_hit;

    assign addr_ok       = (32'(wr_addr) < NPIX);
    assign ram_we        = wr_en && (state == IDLE) && addr_ok;
    assign last_col      = (col == 16'(IMG_WIDTH - 1));
    assign last_row      = (row == 16'(IMG_HEIGHT - 1));
    assign to_hit        = (to_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign accept_launch = (state == IDLE) && launch;
    assign done_hit      = (state == WAIT_DONE) && final_done_signal;

    frame_buffer_ram #(
        .DEPTH  (NPIX),
        .WIDTH  (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Next state; the buffer read is issued whenever the next cycle streams,
    // which gives the one-cycle prefetch the registered RAM needs.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (launch) state_nxt = START;
            START:     state_nxt = STREAM;
            STREAM: begin
                if (last_col) begin
                    if (last_row)         state_nxt = WAIT_DONE;
                    else if (ROW_GAP > 0) state_nxt = GAP;
                end
            end
            GAP:       if (gap_cnt == 16'(ROW_GAP - 1)) state_nxt = STREAM;
            WAIT_DONE: if (final_done_signal || to_hit) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        rd_en = (state_nxt == STREAM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            gap_cnt     <= '0;
            to_cnt      <= '0;
            rd_ptr      <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            wr_err      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == IDLE)  rd_ptr <= '0;
            else if (rd_en)     rd_ptr <= rd_ptr + 1'b1;

            if (state == STREAM) begin
                if (last_col) begin
                    col <= '0;
                    row <= row + 16'd1;
                end else begin
                    col <= col + 16'd1;
                end
            end else if (state == IDLE) begin
                col <= '0;
                row <= '0;
            end

            gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : '0;
            to_cnt  <= (state == WAIT_DONE) ? to_cnt + 32'd1 : '0;

            frame_done <= done_hit;
            if (done_hit) frame_count <= frame_count + 16'd1;

            // Done takes priority over a simultaneous timeout.
            if (accept_launch)
                timeout_err <= 1'b0;
            else if ((state == WAIT_DONE) && !final_done_signal && to_hit)
                timeout_err <= 1'b1;

            if (accept_launch)
                wr_err <= 1'b0;
            else if (wr_en && (state != IDLE) && addr_ok)
                wr_err <= 1'b1;
        end
    end

    assign start_signal   = (state == START);
    assign pixel_valid_in = (state == STREAM);
    assign pixel_in       = pixel_valid_in ? rd_data : '0;
    assign busy           = (state != IDLE);

endmodule
